exec_unit: RTL and testbench

//  Execute stage of one TIS-100 node, directly downstream of the node's instruction ROM.

---
 rtl/exec_unit.sv | 153 +++++++++++++++
 tb/tb_exec_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute stage of one TIS-100 node: decodes the ROM opcode, owns ACC/BAK and
// runs the per-direction port handshakes; step tells the ROM the instruction retired.
module exec_unit #(
   parameter logic signed [10:0] ACC_MAX = 11'sd999
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [20:0]        opcode,
   output logic [3:0]         instr,
   output logic signed [10:0] acc,
   output logic signed [10:0] jmp_off,
   output logic               step,
   input  logic [43:0]        in_data,
   input  logic [3:0]         in_valid,
   output logic [3:0]         in_ready,
   output logic signed [10:0] out_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic               state_dbg
);

   // Handshake: a word moves on a clock edge where valid and ready are both high
   // for the same direction; out_data/out_valid hold stable until that edge.
   localparam logic [3:0] OP_NOP = 4'd0,  OP_MOV = 4'd1,  OP_SWP = 4'd2,  OP_SAV = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_NEG = 4'd6,  OP_JMP = 4'd7;
   localparam logic [3:0] OP_JEZ = 4'd8,  OP_JNZ = 4'd9,  OP_JGZ = 4'd10, OP_JLZ = 4'd11;
   localparam logic [3:0] OP_JRO = 4'd12;

   localparam logic signed [11:0] MAX12 = {ACC_MAX[10], ACC_MAX};
   localparam logic signed [11:0] MIN12 = -MAX12;

   typedef enum logic {S_EXEC = 1'b0, S_WRITE = 1'b1} state_t;

   state_t             state_q, state_d;
   logic signed [10:0] acc_q, acc_d;
   logic signed [10:0] bak_q, bak_d;
   logic signed [10:0] out_q, out_d;
   logic [1:0]         wr_dir_q, wr_dir_d;

   logic [2:0]         src_sel, dst_sel;
   logic signed [10:0] imm;
   logic [1:0]         src_port, dst_port;
   logic               uses_src, need_port, transfer, src_avail;
   logic               dst_is_port, exec_fire, write_done;
   logic signed [10:0] src_val, port_word;
   logic signed [11:0] sum_w, diff_w;

   function automatic logic signed [10:0] sat(input logic signed [11:0] v);
      if (v > MAX12)      return MAX12[10:0];
      else if (v < MIN12) return MIN12[10:0];
      else                return v[10:0];
   endfunction

   assign instr    = opcode[20:17];
   assign src_sel  = opcode[16:14];
   assign dst_sel  = opcode[13:11];
   assign imm      = opcode[10:0];
   assign src_port = 2'(src_sel - 3'd3);
   assign dst_port = 2'(dst_sel - 3'd2);

   assign uses_src    = (instr == OP_MOV) || (instr == OP_ADD) || (instr == OP_SUB) || (instr == OP_JRO);
   assign need_port   = uses_src && (src_sel >= 3'd3) && (src_sel <= 3'd6);
   assign dst_is_port = (dst_sel >= 3'd2) && (dst_sel <= 3'd5);
   assign port_word   = in_data[11*src_port +: 11];

   always_comb begin
      src_val = '0;
      case (src_sel)
         3'd0:                   src_val = sat({imm[10], imm});
         3'd1:                   src_val = acc_q;
         3'd3, 3'd4, 3'd5, 3'd6: src_val = sat({port_word[10], port_word});
         default:                src_val = '0;
      endcase
   end

   assign in_ready   = (state_q == S_EXEC && en && !reset && need_port) ? (4'b0001 << src_port) : 4'b0000;
   assign transfer   = |(in_ready & in_valid);
   assign src_avail  = !need_port || transfer;
   assign exec_fire  = (state_q == S_EXEC) && en && !reset && src_avail;
   assign write_done = (state_q == S_WRITE) && en && !reset && out_ready[wr_dir_q];

   assign sum_w  = {acc_q[10], acc_q} + {src_val[10], src_val};
   assign diff_w = {acc_q[10], acc_q} - {src_val[10], src_val};

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      bak_d    = bak_q;
      out_d    = out_q;
      wr_dir_d = wr_dir_q;
      step     = 1'b0;
      if (exec_fire) begin
         step = 1'b1;
         case (instr)
            OP_MOV: begin
               if (dst_is_port) begin
                  // Port write retires later, once the neighbour accepts the word.
                  step     = 1'b0;
                  out_d    = src_val;
                  wr_dir_d = dst_port;
                  state_d  = S_WRITE;
               end else if (dst_sel == 3'd0) begin
                  acc_d = src_val;
               end
            end
            OP_ADD:  acc_d = sat(sum_w);
            OP_SUB:  acc_d = sat(diff_w);
            OP_NEG:  acc_d = -acc_q;
            OP_SWP: begin
               acc_d = bak_q;
               bak_d = acc_q;
            end
            OP_SAV:  bak_d = acc_q;
            default: ;
         endcase
      end else if (write_done) begin
         step    = 1'b1;
         state_d = S_EXEC;
      end
   end

   always_comb begin
      jmp_off = '0;
      case (instr)
         OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ: jmp_off = imm;
         OP_JRO:                                 jmp_off = src_val;
         default:                                jmp_off = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_EXEC;
         acc_q    <= '0;
         bak_q    <= '0;
         out_q    <= '0;
         wr_dir_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         bak_q    <= bak_d;
         out_q    <= out_d;
         wr_dir_q <= wr_dir_d;
      end
   end

   assign acc       = acc_q;
   assign out_data  = out_q;
   assign out_valid = (state_q == S_WRITE) ? (4'b0001 << wr_dir_q) : 4'b0000;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: a table of single-cycle register ops, then
// hand-written port read/write, saturation, enable and reset-mid-write sequences.
module tb_exec_unit;

   localparam int OP_NOP = 0, OP_MOV = 1, OP_SWP = 2, OP_SAV = 3, OP_ADD = 4, OP_SUB = 5;
   localparam int OP_NEG = 6, OP_JMP = 7, OP_JLZ = 11, OP_JRO = 12;
   localparam int S_IMM = 0, S_ACC = 1, S_NIL = 2, S_UP = 3, S_LEFT = 5, S_RES = 7;
   localparam int D_ACC = 0, D_NIL = 1, D_DOWN = 3, D_RIGHT = 5;

   logic               clk = 1'b0;
   logic               reset, en;
   logic [20:0]        opcode;
   logic [3:0]         instr;
   logic signed [10:0] acc, jmp_off, out_data;
   logic               step, state_dbg;
   logic [43:0]        in_data;
   logic [3:0]         in_valid, in_ready, out_valid, out_ready;

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];

   typedef struct {
      logic [20:0] op;
      logic        en;
      logic        exp_step;
      int          exp_jmp;
      int          exp_acc;
   } vec_t;

   vec_t vecs[23];

   exec_unit dut (
      .clk(clk), .reset(reset), .en(en), .opcode(opcode), .instr(instr),
      .acc(acc), .jmp_off(jmp_off), .step(step), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [20:0] mk(input int op, input int src, input int dst, input int imm);
      logic [31:0] o, s, d, m;
      o = op; s = src; d = dst; m = imm;
      return {o[3:0], s[2:0], d[2:0], m[10:0]};
   endfunction

   function automatic vec_t v(input logic [20:0] op, input logic e, input logic st,
                              input int jmp, input int a);
      vec_t r;
      r.op = op; r.en = e; r.exp_step = st; r.exp_jmp = jmp; r.exp_acc = a;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic [20:0] op, input logic e, input logic [3:0] iv,
                        input logic [43:0] id, input logic [3:0] ordy);
      opcode = op; en = e; in_valid = iv; in_data = id; out_ready = ordy;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [43:0] d;
      reset = 1'b1;
      drive(21'd0, 1'b0, 4'b0, 44'd0, 4'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      to_neg();
      chk("reset_acc", acc, 0);
      chk("reset_step", step, 0);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_state", state_dbg, 0);
      to_pos();

      vecs[0]  = v(mk(OP_ADD, S_IMM, D_ACC, 600),   1, 1, 0, 600);
      vecs[1]  = v(mk(OP_ADD, S_IMM, D_ACC, 600),   1, 1, 0, 999);
      vecs[2]  = v(mk(OP_SUB, S_IMM, D_ACC, 1023),  1, 1, 0, 0);
      vecs[3]  = v(mk(OP_SUB, S_IMM, D_ACC, 1023),  1, 1, 0, -999);
      vecs[4]  = v(mk(OP_SUB, S_IMM, D_ACC, 1000),  1, 1, 0, -999);
      vecs[5]  = v(mk(OP_ADD, S_IMM, D_ACC, 5),     0, 0, 0, -999);
      vecs[6]  = v(mk(OP_MOV, S_IMM, D_ACC, 5),     1, 1, 0, 5);
      vecs[7]  = v(mk(OP_SAV, 0, 0, 0),             1, 1, 0, 5);
      vecs[8]  = v(mk(OP_NEG, 0, 0, 0),             1, 1, 0, -5);
      vecs[9]  = v(mk(OP_SWP, 0, 0, 0),             1, 1, 0, 5);
      vecs[10] = v(mk(OP_SWP, 0, 0, 0),             1, 1, 0, -5);
      vecs[11] = v(mk(OP_SWP, 0, 0, 0),             1, 1, 0, 5);
      vecs[12] = v(mk(OP_MOV, S_IMM, D_ACC, -3),    1, 1, 0, -3);
      vecs[13] = v(mk(OP_JRO, S_ACC, 0, 0),         1, 1, -3, -3);
      vecs[14] = v(mk(OP_JMP, 0, 0, 17),            1, 1, 17, -3);
      vecs[15] = v(mk(OP_JLZ, 0, 0, -100),          1, 1, -100, -3);
      vecs[16] = v(mk(OP_ADD, S_ACC, D_ACC, 0),     1, 1, 0, -6);
      vecs[17] = v(mk(OP_NEG, 0, 0, 0),             1, 1, 0, 6);
      vecs[18] = v(mk(OP_MOV, S_ACC, D_NIL, 0),     1, 1, 0, 6);
      vecs[19] = v(mk(OP_ADD, S_IMM, D_ACC, -1024), 1, 1, 0, -993);
      vecs[20] = v(mk(OP_ADD, S_NIL, D_ACC, 77),    1, 1, 0, -993);
      vecs[21] = v(mk(OP_NOP, 0, 0, 55),            1, 1, 0, -993);
      vecs[22] = v(mk(OP_SUB, S_RES, D_ACC, 9),     1, 1, 0, -993);

      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].op, vecs[i].en, 4'b0, 44'd0, 4'b0);
         to_neg();
         chk($sformatf("vec%0d_step", i), step, vecs[i].exp_step);
         chk($sformatf("vec%0d_jmp", i), jmp_off, vecs[i].exp_jmp);
         chk($sformatf("vec%0d_in_ready", i), in_ready, 0);
         to_pos();
         chk($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
      end
      chk("instr_field", instr, OP_SUB);

      // MOV UP, ACC: stall on missing valid, then an en=0 cycle, then transfer
      d = 44'd0;
      d[10:0] = -11'sd42;
      for (int k = 0; k < 3; k++) begin
         drive(mk(OP_MOV, S_UP, D_ACC, 0), 1'b1, 4'b0000, d, 4'b0);
         to_neg();
         chk($sformatf("rd_wait%0d_step", k), step, 0);
         chk($sformatf("rd_wait%0d_in_ready", k), in_ready, 4'b0001);
         to_pos();
         chk($sformatf("rd_wait%0d_acc", k), acc, -993);
      end
      drive(mk(OP_MOV, S_UP, D_ACC, 0), 1'b0, 4'b0001, d, 4'b0);
      to_neg();
      chk("rd_en0_in_ready", in_ready, 0);
      chk("rd_en0_step", step, 0);
      to_pos();
      chk("rd_en0_acc", acc, -993);
      drive(mk(OP_MOV, S_UP, D_ACC, 0), 1'b1, 4'b0001, d, 4'b0);
      to_neg();
      chk("rd_xfer_step", step, 1);
      chk("rd_xfer_in_ready", in_ready, 4'b0001);
      to_pos();
      chk("rd_xfer_acc", acc, -42);

      // MOV 7, RIGHT: held offer while out_ready[3] stays low
      exp_q.push_back(11'd7);
      drive(mk(OP_MOV, S_IMM, D_RIGHT, 7), 1'b1, 4'b0, 44'd0, 4'b0);
      to_neg();
      chk("wr_entry_step", step, 0);
      chk("wr_entry_out_valid", out_valid, 0);
      to_pos();
      for (int k = 0; k < 4; k++) begin
         out_ready = (k == 3) ? 4'b0111 : 4'b0000;
         to_neg();
         chk($sformatf("wr_wait%0d_out_valid", k), out_valid, 4'b1000);
         chk($sformatf("wr_wait%0d_out_data", k), out_data, 7);
         chk($sformatf("wr_wait%0d_step", k), step, 0);
         to_pos();
      end
      en = 1'b0;
      out_ready = 4'b1000;
      to_neg();
      chk("wr_en0_step", step, 0);
      chk("wr_en0_out_valid", out_valid, 4'b1000);
      to_pos();
      en = 1'b1;
      to_neg();
      chk("wr_done_step", step, 1);
      if (exp_q.size() == 0) chk("wr_done_queue", 0, 1);
      else chk("wr_done_out_data", out_data, $signed(exp_q.pop_front()));
      to_pos();
      drive(mk(OP_NOP, 0, 0, 0), 1'b0, 4'b0, 44'd0, 4'b0);
      to_neg();
      chk("wr_after_out_valid", out_valid, 0);
      chk("wr_after_acc", acc, -42);
      chk("wr_after_state", state_dbg, 0);

      // Port values beyond the saturation bound
      d = 44'd0;
      d[32:22] = 11'sd1023;
      to_pos();
      drive(mk(OP_JRO, S_LEFT, 0, 0), 1'b1, 4'b0100, d, 4'b0);
      to_neg();
      chk("jro_left_in_ready", in_ready, 4'b0100);
      chk("jro_left_step", step, 1);
      chk("jro_left_jmp", jmp_off, 999);
      to_pos();
      chk("jro_left_acc", acc, -42);
      d[32:22] = -11'sd1024;
      drive(mk(OP_MOV, S_LEFT, D_ACC, 0), 1'b1, 4'b0100, d, 4'b0);
      to_pos();
      chk("mov_left_neg_sat", acc, -999);

      // Reset asserted while a write is pending
      drive(mk(OP_MOV, S_IMM, D_ACC, 33), 1'b1, 4'b0, 44'd0, 4'b0);
      to_pos();
      drive(mk(OP_SAV, 0, 0, 0), 1'b1, 4'b0, 44'd0, 4'b0);
      to_pos();
      chk("pre_reset_acc", acc, 33);
      drive(mk(OP_MOV, S_IMM, D_DOWN, 9), 1'b1, 4'b0, 44'd0, 4'b0);
      to_pos();
      to_neg();
      chk("rst_wr_out_valid", out_valid, 4'b0010);
      chk("rst_wr_out_data", out_data, 9);
      reset = 1'b1;
      to_pos();
      reset = 1'b0;
      en = 1'b0;
      to_neg();
      chk("rst_wr_after_out_valid", out_valid, 0);
      chk("rst_wr_after_acc", acc, 0);
      chk("rst_wr_after_state", state_dbg, 0);
      to_pos();
      drive(mk(OP_SWP, 0, 0, 0), 1'b1, 4'b0, 44'd0, 4'b0);
      to_pos();
      chk("rst_bak_cleared", acc, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
